// File: rtl/mm_port_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter: FSM encoding, the
// default widths/timings used by cache and mainmemory, and the counter sizing helper.
package mm_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_RD_WAIT = 2'd1,
    ARB_WR_WAIT = 2'd2
  } arb_state_e;

  localparam int DEF_AW         = 32;
  localparam int DEF_DW         = 256;
  localparam int DEF_WRITE_TPUT = 4;
  localparam int DEF_RD_TIMEOUT = 64;

  // Wide enough that neither the watchdog nor the write spacing can wrap.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/mm_arb_timer.sv
// Loadable up/down counter with a terminal-value flag. The count holds once
// it reaches the terminal value, so it can never wrap.
module mm_arb_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_up,
  input  logic [W-1:0] i_term_val,
  output logic         o_term
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_en && !o_term)
      r_cnt <= i_up ? r_cnt + 1'b1 : r_cnt - 1'b1;
  end

  assign o_term = (r_cnt == i_term_val);

endmodule

// File: rtl/mm_port_arbiter.sv
// Round-robin sharing of the single main-memory port between the L1 data side
// (r0) and the fill/prefetch side (r1), one transaction in flight at a time.
module mm_port_arbiter
  import mm_port_arbiter_pkg::*;
#(
  parameter int WRITE_TPUT = DEF_WRITE_TPUT,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT,
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   r0_a,
  input  logic [DW/8-1:0] r0_be,
  input  logic            r0_read,
  input  logic            r0_write,
  input  logic [DW-1:0]   r0_wd,
  output logic            r0_gnt,
  output logic [DW-1:0]   r0_rd,
  output logic            r0_rd_valid,
  input  logic [AW-1:0]   r1_a,
  input  logic [DW/8-1:0] r1_be,
  input  logic            r1_read,
  input  logic            r1_write,
  input  logic [DW-1:0]   r1_wd,
  output logic            r1_gnt,
  output logic [DW-1:0]   r1_rd,
  output logic            r1_rd_valid,
  output logic [AW-1:0]   mm_a,
  output logic [DW/8-1:0] mm_be,
  output logic            mm_read,
  output logic            mm_write,
  output logic [DW-1:0]   mm_wd,
  input  logic [DW-1:0]   mm_rd,
  input  logic            mm_valid,
  output logic            busy,
  output logic            owner,
  output logic            err
);

  localparam int CW      = cnt_width(RD_TIMEOUT, WRITE_TPUT);
  // Leaving WR_WAIT one count early lets IDLE sample on the cycle that makes
  // back-to-back writes exactly WRITE_TPUT apart.
  localparam int WR_TERM = (WRITE_TPUT > 1) ? 1 : 0;

  arb_state_e      r_state, w_next;
  logic            r_last, r_owner, r_stale;
  logic            r_gnt0, r_gnt1, r_mrd, r_mwr, r_err;
  logic [AW-1:0]   r_a;
  logic [DW/8-1:0] r_be;
  logic [DW-1:0]   r_wd;
  logic            w_req0, w_req1, w_win, w_issue, w_wr, w_rd, w_term;
  logic            w_tmo, w_stray, w_err;
  logic [CW-1:0]   w_load_val, w_term_val;

  assign w_req0  = r0_read | r0_write;
  assign w_req1  = r1_read | r1_write;
  assign w_win   = (w_req0 && w_req1) ? ~r_last : w_req1;
  assign w_issue = (r_state == ARB_IDLE) && (w_req0 || w_req1);
  assign w_wr    = w_win ? r1_write : r0_write;
  assign w_rd    = w_win ? r1_read  : r0_read;

  assign w_load_val = w_wr ? CW'(WRITE_TPUT - 1) : '0;
  assign w_term_val = (r_state == ARB_RD_WAIT) ? CW'(RD_TIMEOUT - 1) : CW'(WR_TERM);

  mm_arb_timer #(.W(CW)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_issue),
    .i_load_val(w_load_val),
    .i_en      (r_state != ARB_IDLE),
    .i_up      (r_state == ARB_RD_WAIT),
    .i_term_val(w_term_val),
    .o_term    (w_term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ARB_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:    if (w_issue) w_next = w_wr ? ARB_WR_WAIT : ARB_RD_WAIT;
      ARB_RD_WAIT: if (mm_valid || w_term) w_next = ARB_IDLE;
      ARB_WR_WAIT: if (w_term) w_next = ARB_IDLE;
      default:     w_next = ARB_IDLE;
    endcase
  end

  // r_stale marks a read possibly left in flight by reset; its data is dropped quietly.
  always_comb begin
    r0_rd_valid = 1'b0;
    r1_rd_valid = 1'b0;
    w_tmo       = 1'b0;
    w_stray     = 1'b0;
    case (r_state)
      ARB_RD_WAIT: begin
        r0_rd_valid = mm_valid & ~r_owner;
        r1_rd_valid = mm_valid &  r_owner;
        w_tmo       = w_term & ~mm_valid;
      end
      ARB_IDLE:    w_stray = mm_valid & ~r_stale;
      ARB_WR_WAIT: w_stray = mm_valid;
      default:     ;
    endcase
  end

  assign w_err = (w_issue & w_wr & w_rd) | w_tmo | w_stray;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_stale <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_mrd   <= 1'b0;
      r_mwr   <= 1'b0;
      r_err   <= 1'b0;
      r_a     <= '0;
      r_be    <= '0;
      r_wd    <= '0;
    end else begin
      r_gnt0 <= w_issue & ~w_win;
      r_gnt1 <= w_issue &  w_win;
      r_mrd  <= w_issue & ~w_wr;
      r_mwr  <= w_issue &  w_wr;
      r_err  <= w_err;
      if (w_issue) begin
        r_a     <= w_win ? r1_a  : r0_a;
        r_be    <= w_win ? r1_be : r0_be;
        r_wd    <= w_win ? r1_wd : r0_wd;
        r_owner <= w_win;
        r_last  <= w_win;
        r_stale <= 1'b0;
      end else if (mm_valid && r_state == ARB_IDLE) begin
        r_stale <= 1'b0;
      end
    end
  end

  assign r0_gnt   = r_gnt0;
  assign r1_gnt   = r_gnt1;
  assign mm_read  = r_mrd;
  assign mm_write = r_mwr;
  assign mm_a     = r_a;
  assign mm_be    = r_be;
  assign mm_wd    = r_wd;
  assign err      = r_err;
  assign owner    = r_owner;
  assign busy     = (r_state != ARB_IDLE);
  assign r0_rd    = mm_rd;
  assign r1_rd    = mm_rd;

endmodule

// File: tb/tb_mm_port_arbiter.sv
// Randomised bench for mm_port_arbiter: a transaction-level arbitration model
// feeds expectation queues that a negedge monitor drains against the DUT.
module tb_mm_port_arbiter;

  localparam int AW = 32, DW = 256, BW = DW / 8;
  localparam int WRITE_TPUT = 4, RD_TIMEOUT = 64, READ_LAT = 4;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] be;
    logic [255:0] wd;
  } txn_t;
  typedef struct {
    bit          who;
    bit          wr;
    logic [31:0] a;
    logic [31:0] be;
    logic [255:0] wd;
  } iss_t;
  typedef struct {
    bit           who;
    logic [255:0] d;
  } rd_t;

  logic          clk, reset;
  logic [AW-1:0] r0_a, r1_a, mm_a;
  logic [BW-1:0] r0_be, r1_be, mm_be;
  logic          r0_read, r0_write, r1_read, r1_write;
  logic [DW-1:0] r0_wd, r1_wd, r0_rd, r1_rd, mm_wd, mm_rd;
  logic          r0_gnt, r1_gnt, r0_rd_valid, r1_rd_valid;
  logic          mm_read, mm_write, mm_valid, busy, owner, err;

  mm_port_arbiter #(.WRITE_TPUT(WRITE_TPUT), .RD_TIMEOUT(RD_TIMEOUT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .r0_a(r0_a), .r0_be(r0_be), .r0_read(r0_read), .r0_write(r0_write), .r0_wd(r0_wd),
    .r0_gnt(r0_gnt), .r0_rd(r0_rd), .r0_rd_valid(r0_rd_valid),
    .r1_a(r1_a), .r1_be(r1_be), .r1_read(r1_read), .r1_write(r1_write), .r1_wd(r1_wd),
    .r1_gnt(r1_gnt), .r1_rd(r1_rd), .r1_rd_valid(r1_rd_valid),
    .mm_a(mm_a), .mm_be(mm_be), .mm_read(mm_read), .mm_write(mm_write), .mm_wd(mm_wd),
    .mm_rd(mm_rd), .mm_valid(mm_valid), .busy(busy), .owner(owner), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  int   cyc = 0;
  iss_t iss_q[$];
  rd_t  rd_q[$];
  bit   mdl_last = 1'b1;
  int   err_exp = 0, err_seen = 0, err_cyc = 0, rd_iss_cyc = 0;
  int   wr_prev = 0, wr_last = 0;
  logic busy_at_err = 1'b0;
  int   pend = 0;
  bit   no_resp = 1'b0, stray = 1'b0;
  logic [255:0] pdata;
  int   first_lat = 0;
  bit   first_who = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] memf(input logic [31:0] a);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = a ^ (32'h5A5A_0F0F + 32'(i));
    return d;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Main memory stand-in: fixed read latency, optional silence, injectable stray valid.
  initial begin
    mm_valid = 1'b0;
    mm_rd    = '0;
    forever begin
      @(posedge clk); #1;
      mm_valid = 1'b0;
      mm_rd    = '0;
      if (stray) begin
        mm_valid = 1'b1;
        mm_rd    = {8{32'hDEAD_BEEF}};
        stray    = 1'b0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mm_valid = 1'b1;
          mm_rd    = pdata;
        end
      end
      if (mm_read && !no_resp) begin
        pend  = READ_LAT;
        pdata = memf(mm_a);
      end
    end
  end

  // Monitor: every strobe and every rd_valid consumes one expectation.
  initial begin
    iss_t e;
    rd_t  r;
    forever begin
      @(negedge clk);
      if (r0_rd_valid || r1_rd_valid) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected actual r0=%0b r1=%0b expected none", r0_rd_valid, r1_rd_valid);
        end else begin
          r = rd_q.pop_front();
          chk("rd_who", {r1_rd_valid, r0_rd_valid}, r.who ? 2'b10 : 2'b01);
          chk("rd_data", r.who ? r1_rd : r0_rd, r.d);
        end
      end
      if (mm_read || mm_write) begin
        if (iss_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL iss_unexpected actual rd=%0b wr=%0b a=%0h expected none", mm_read, mm_write, mm_a);
        end else begin
          e = iss_q.pop_front();
          chk("iss_kind", {mm_write, mm_read}, e.wr ? 2'b10 : 2'b01);
          chk("iss_gnt", {r1_gnt, r0_gnt}, e.who ? 2'b10 : 2'b01);
          chk("iss_owner", owner, e.who);
          chk("mm_a", mm_a, e.a);
          chk("mm_be", mm_be, e.be);
          if (e.wr) chk("mm_wd", mm_wd, e.wd);
        end
        if (mm_write) begin wr_prev = wr_last; wr_last = cyc; end
        if (mm_read) rd_iss_cyc = cyc;
      end else if (r0_gnt || r1_gnt) begin
        checks++; errors++;
        $display("FAIL gnt_without_strobe actual gnt=%0b%0b expected 00", r1_gnt, r0_gnt);
      end
      if (err) begin
        err_seen++;
        err_cyc     = cyc;
        busy_at_err = busy;
      end
    end
  end

  function automatic txn_t mk(input bit rd, input bit wr, input logic [31:0] a);
    txn_t t;
    t.rd = rd; t.wr = wr; t.a = a; t.be = $urandom;
    for (int i = 0; i < 8; i++) t.wd[i*32 +: 32] = $urandom;
    return t;
  endfunction

  // Reference arbitration: a lone requester wins; a tie goes to the side
  // that did not win last, and the loser is served next.
  task automatic model_push(input bit who, input txn_t t);
    iss_t e;
    rd_t  r;
    e.who = who; e.wr = t.wr; e.a = t.a; e.be = t.be; e.wd = t.wd;
    iss_q.push_back(e);
    if (t.wr && t.rd) err_exp++;
    if (!t.wr && !no_resp) begin
      r.who = who; r.d = memf(t.a);
      rd_q.push_back(r);
    end
    mdl_last = who;
  endtask

  // Called and returns at posedge+#1; each request is held until its gnt is seen.
  task automatic do_round(input bit v0, input bit v1, input txn_t t0, input txn_t t1);
    bit p0, p1, g0, g1, seen;
    int n, start;
    if (v0 && v1) begin
      if (mdl_last) begin model_push(1'b0, t0); model_push(1'b1, t1); end
      else          begin model_push(1'b1, t1); model_push(1'b0, t0); end
    end else if (v0) model_push(1'b0, t0);
    else if (v1)     model_push(1'b1, t1);
    r0_read = v0 & t0.rd; r0_write = v0 & t0.wr; r0_a = t0.a; r0_be = t0.be; r0_wd = t0.wd;
    r1_read = v1 & t1.rd; r1_write = v1 & t1.wr; r1_a = t1.a; r1_be = t1.be; r1_wd = t1.wd;
    p0 = v0; p1 = v1; n = 0; seen = 1'b0; start = cyc;
    while ((p0 || p1) && n < 300) begin
      @(negedge clk);
      g0 = r0_gnt; g1 = r1_gnt;
      if (!seen && (g0 || g1)) begin
        seen = 1'b1; first_lat = cyc - start; first_who = g1;
      end
      @(posedge clk); #1;
      if (g0) begin p0 = 1'b0; r0_read = 1'b0; r0_write = 1'b0; end
      if (g1) begin p1 = 1'b0; r1_read = 1'b0; r1_write = 1'b0; end
      n++;
    end
    if (p0 || p1) begin
      checks++; errors++;
      $display("FAIL grant_timeout actual pending=%0b%0b expected 00", p1, p0);
      r0_read = 1'b0; r0_write = 1'b0; r1_read = 1'b0; r1_write = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || pend != 0 || rd_q.size() != 0 || iss_q.size() != 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual busy=%0b rdq=%0d expected idle", busy, rd_q.size());
    end
  endtask

  initial begin
    txn_t t0, t1, tn;
    #500000;
    $display("FAIL global_timeout actual cyc=%0d expected completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    txn_t t0, t1, tn;
    int   pat;
    tn = mk(1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    r0_read = 0; r0_write = 0; r0_a = 0; r0_be = 0; r0_wd = 0;
    r1_read = 0; r1_write = 0; r1_a = 0; r1_be = 0; r1_wd = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_gnt", {r1_gnt, r0_gnt}, 0);
    chk("rst_strobe", {mm_write, mm_read}, 0);
    chk("rst_err", err, 0);
    chk("rst_mm_a", mm_a, 0);
    chk("rst_mm_be", mm_be, 0);
    chk("rst_mm_wd", mm_wd, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Lone r0 read at 0x100.
    t0 = mk(1'b1, 1'b0, 32'h100);
    do_round(1'b1, 1'b0, t0, tn);
    chk("solo_gnt_lat", first_lat, 1);
    wait_idle();

    // Four same-cycle read ties.
    for (int i = 0; i < 4; i++) begin
      t0 = mk(1'b1, 1'b0, $urandom);
      t1 = mk(1'b1, 1'b0, $urandom);
      do_round(1'b1, 1'b1, t0, t1);
    end
    wait_idle();

    // r1 back-to-back full-line writes.
    t1 = mk(1'b0, 1'b1, 32'h2000); t1.be = '1;
    do_round(1'b0, 1'b1, tn, t1);
    t1 = mk(1'b0, 1'b1, 32'h2020); t1.be = '1;
    do_round(1'b0, 1'b1, tn, t1);
    wait_idle();
    chk("wr_spacing", wr_last - wr_prev, WRITE_TPUT);

    // Read that memory never answers.
    no_resp = 1'b1;
    t0 = mk(1'b1, 1'b0, 32'h300);
    do_round(1'b1, 1'b0, t0, tn);
    err_exp++;
    wait_idle();
    no_resp = 1'b0;
    chk("tmo_latency", err_cyc - rd_iss_cyc, RD_TIMEOUT);
    chk("tmo_busy", busy_at_err, 0);
    chk("tmo_err_cnt", err_seen, err_exp);
    t1 = mk(1'b1, 1'b0, 32'h340);
    do_round(1'b0, 1'b1, tn, t1);
    wait_idle();

    // Read+write together, then a stray mm_valid while idle.
    t0 = mk(1'b1, 1'b1, 32'h400);
    do_round(1'b1, 1'b0, t0, tn);
    wait_idle();
    chk("rdwr_err_cnt", err_seen, err_exp);
    stray = 1'b1;
    err_exp++;
    repeat (3) begin @(posedge clk); #1; end
    chk("stray_err_cnt", err_seen, err_exp);

    // Reset two cycles into RD_WAIT; the late data must vanish silently.
    t0 = mk(1'b1, 1'b0, 32'h500);
    do_round(1'b1, 1'b0, t0, tn);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_owner", owner, 0);
    chk("mid_rst_strobes", {err, mm_write, mm_read, r1_gnt, r0_gnt}, 0);
    chk("mid_rst_rdv", {r1_rd_valid, r0_rd_valid}, 0);
    chk("mid_rst_mm_a", mm_a, 0);
    rd_q.delete();
    mdl_last = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("late_valid_err", err_seen, err_exp);
    t0 = mk(1'b1, 1'b0, $urandom);
    t1 = mk(1'b1, 1'b0, $urandom);
    do_round(1'b1, 1'b1, t0, t1);
    chk("post_rst_tie", first_who, 0);
    wait_idle();

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      pat = $urandom_range(1, 3);
      t0 = mk(1'b0, 1'b0, $urandom);
      t1 = mk(1'b0, 1'b0, $urandom);
      t0.rd = $urandom_range(0, 1); t0.wr = !t0.rd;
      t1.rd = $urandom_range(0, 1); t1.wr = !t1.rd;
      do_round(pat[0], pat[1], t0, t1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_idle();
    chk("end_iss_q", iss_q.size(), 0);
    chk("end_rd_q", rd_q.size(), 0);
    chk("end_err_cnt", err_seen, err_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
